pb_gpio_ext: RTL and testbench
==============================

PB_GPIO_EXT -- requirements
Module: pb_gpio_ext

Interface
REQ-001 SHALL have parameter WIDTH, default 8: number of GPIO bits (1..32).
REQ-002 SHALL have parameter SYNC_STAGES, default 2: input synchroniser depth (2..4).
REQ-003 SHALL have parameter DEBOUNCE_CYCLES, default 16: stable-cycle count for the debounce filter (1..65535); ignored unless PB_GPIO_EXT_DEBOUNCE_EN is defined.
REQ-004 SHALL have port clk_i, input, 1: the single clock.
REQ-005 SHALL have port rst_i, input, 1: reset, synchronous and active-high.
REQ-006 SHALL have port gpio, inout, WIDTH: pads.
REQ-007 SHALL have port gpio_oe, input, WIDTH: per-bit output enable.
REQ-008 SHALL have port gpio_enable, input, WIDTH: per-bit pin enable.
REQ-009 SHALL have port gpio_data_i, input, WIDTH: value written by firmware.
REQ-010 SHALL have port gpio_data_o, output, WIDTH: input value read by firmware.
REQ-011 SHALL have port int_en_i, input, WIDTH: per-bit interrupt enable.
REQ-012 SHALL have port int_rise_i, input, WIDTH: per-bit rising-edge select.
REQ-013 SHALL have port int_fall_i, input, WIDTH: per-bit falling-edge select.
REQ-014 SHALL have port int_clr_i, input, WIDTH: per-bit one-cycle write-1-to-clear pulse for status.
REQ-015 SHALL have port int_status_o, output, WIDTH: sticky per-bit event flags.
REQ-016 SHALL have port int_o, output, 1: aggregate interrupt.

Function
REQ-017 Bit n SHALL drive gpio[n]=gpio_data_i[n] when gpio_oe[n]&gpio_enable[n]; otherwise high-Z. This path is combinational.
REQ-018 Each pad SHALL pass through a SYNC_STAGES flop chain to give sync[n]; filt[n] is sync[n], or the debounced value (REQ-029).
REQ-019 gpio_data_o[n] SHALL register filt[n]&~gpio_oe[n]&gpio_enable[n]; latency pin->gpio_data_o is SYNC_STAGES+1 cycles without debounce.
REQ-020 Register prev[n] SHALL load filt[n] every cycle, regardless of oe/enable, so a direction change never creates a false edge.
REQ-021 rise[n]=filt&~prev; fall[n]=~filt&prev; qual[n]=~gpio_oe[n]&gpio_enable[n]&int_en_i[n].
REQ-022 int_status_o[n] SHALL set next cycle when qual[n]&((rise&int_rise_i)|(fall&int_fall_i)); rise and fall both selected = any edge; neither selected = no events.
REQ-023 int_status_o[n] SHALL clear on int_clr_i[n]; a same-cycle set and clear SHALL leave the bit set (no event lost).
REQ-024 Clearing int_en_i[n] SHALL NOT clear int_status_o[n]; it only masks it from int_o.
REQ-025 int_o SHALL be registered: int_o <= |(int_status_o & int_en_i); it SHALL assert one cycle after the status bit sets.
REQ-026 All bits SHALL be independent; simultaneous edges on several bits SHALL each set their own status bit.

Reset
REQ-027 On rst_i, synchroniser chains, prev, gpio_data_o, int_status_o and int_o SHALL go to 0, and debounce counters to 0 with filt at 0; gpio tri-state follows REQ-017 combinationally.
REQ-028 A reset asserted mid-debounce or with pending status SHALL discard all state; the first cycle after reset with a pin high SHALL produce a rising edge only after the full sync (and debounce) latency.

Configuration
REQ-029 With PB_GPIO_EXT_DEBOUNCE_EN defined, each bit SHALL have a counter that resets whenever sync[n]==filt[n], and increments otherwise. filt[n] SHALL toggle when the counter reaches DEBOUNCE_CYCLES-1 while sync still differs, and the counter SHALL then reset; glitches shorter than DEBOUNCE_CYCLES cycles SHALL be invisible.
REQ-030 Without the macro, no counters SHALL be built, and filt=sync.

Structure
REQ-031 Shared package pb_gpio_pkg SHALL hold the SYNC_STAGES and DEBOUNCE_CYCLES defaults and the counter-width clog2 function.
REQ-032 One sub-module, pb_gpio_debounce (1 bit: sync in, filt out), SHALL be instantiated WIDTH times under the macro.

Verification
REQ-033 WIDTH=8, no debounce: bit3 input, int_en=0x08, rise=0x08; pad3 0->1 -> gpio_data_o[3]=1 after 3 cycles, int_status_o=0x08 after 3 cycles, int_o=1 one cycle later.
REQ-034 Clear race: int_clr_i=0x08 in the same cycle as a new edge on bit3 -> int_status_o[3] stays 1; a later clear alone -> 0, and int_o drops next cycle.
REQ-035 Direction switch: bit5 pad held 1, gpio_oe[5] 1->0 -> no int_status_o[5] set; gpio_oe=0xFF drives gpio=gpio_data_i=0xA5.
REQ-036 Both edges on bit0 (rise=fall=1) with a 1-0-1 pulse train -> status sets on each edge; with rise=fall=0 -> never sets.
REQ-037 Debounce build, DEBOUNCE_CYCLES=4: 3-cycle glitch -> no change in gpio_data_o or status; 6-cycle level -> accepted after 2+4+1 cycles.
REQ-038 rst_i asserted with int_status_o=0xFF and counters mid-count -> all outputs 0 next cycle; no spurious edge afterwards while pads are stable.

Source files
------------

// File: rtl/pb_gpio_pkg.sv
// Shared defaults and helpers for the pb_gpio_ext GPIO block.
// Debounce logic is built only when PB_GPIO_EXT_DEBOUNCE_EN is defined.
package pb_gpio_pkg;

  localparam int SYNC_STAGES_DEF     = 2;
  localparam int DEBOUNCE_CYCLES_DEF = 16;

  function automatic int cnt_width(input int cycles);
    return (cycles <= 2) ? 1 : $clog2(cycles);
  endfunction

endpackage

// File: rtl/pb_gpio_debounce.sv
// One-bit debounce filter: filt_o follows sync_i only after it has
// held a new value for DEBOUNCE_CYCLES consecutive cycles.
module pb_gpio_debounce
  import pb_gpio_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic sync_i,
  output logic filt_o
);

  localparam int CW = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q  <= '0;
      filt_o <= 1'b0;
    end else if (sync_i == filt_o) begin
      cnt_q <= '0;
    end else if (cnt_q == LAST) begin
      cnt_q  <= '0;
      filt_o <= sync_i;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/pb_gpio_ext.sv
// GPIO block with pad tri-state, input sync, edge interrupts.
// Define PB_GPIO_EXT_DEBOUNCE_EN to add per-bit debounce filters.
module pb_gpio_ext
  import pb_gpio_pkg::*;
#(
  parameter int WIDTH           = 8,
  parameter int SYNC_STAGES     = SYNC_STAGES_DEF,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic             clk_i,
  input  logic             rst_i,
  inout  wire logic [WIDTH-1:0] gpio,
  input  logic [WIDTH-1:0] gpio_oe,
  input  logic [WIDTH-1:0] gpio_enable,
  input  logic [WIDTH-1:0] gpio_data_i,
  output logic [WIDTH-1:0] gpio_data_o,
  input  logic [WIDTH-1:0] int_en_i,
  input  logic [WIDTH-1:0] int_rise_i,
  input  logic [WIDTH-1:0] int_fall_i,
  input  logic [WIDTH-1:0] int_clr_i,
  output logic [WIDTH-1:0] int_status_o,
  output logic             int_o
);

  if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
    $error("pb_gpio_ext: WIDTH out of range");
  end
  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
    $error("pb_gpio_ext: SYNC_STAGES out of range");
  end
  if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 65535) begin : g_bad_db
    $error("pb_gpio_ext: DEBOUNCE_CYCLES out of range");
  end

  logic [WIDTH-1:0] drv;
  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] sync;
  logic [WIDTH-1:0] filt;
  logic [WIDTH-1:0] prev_q;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic [WIDTH-1:0] qual;
  logic [WIDTH-1:0] set;
  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] status_q;
  logic             int_q;

  assign drv = gpio_oe & gpio_enable;

  for (genvar n = 0; n < WIDTH; n++) begin : g_pad
    assign gpio[n] = drv[n] ? gpio_data_i[n] : 1'bz;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int k = 0; k < SYNC_STAGES; k++) begin
        sync_q[k] <= '0;
      end
    end else begin
      sync_q[0] <= gpio;
      for (int k = 1; k < SYNC_STAGES; k++) begin
        sync_q[k] <= sync_q[k-1];
      end
    end
  end

  assign sync = sync_q[SYNC_STAGES-1];

`ifdef PB_GPIO_EXT_DEBOUNCE_EN
  for (genvar n = 0; n < WIDTH; n++) begin : g_db
    pb_gpio_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .sync_i(sync[n]),
      .filt_o(filt[n])
    );
  end
`else
  assign filt = sync;
`endif

  // prev tracks filt even while a bit is an output, so turning
  // a bit back into an input never sees a stale level.
  assign rise = filt & ~prev_q;
  assign fall = ~filt & prev_q;
  assign qual = ~gpio_oe & gpio_enable & int_en_i;
  assign set  = qual & ((rise & int_rise_i) | (fall & int_fall_i));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      prev_q   <= '0;
      data_q   <= '0;
      status_q <= '0;
      int_q    <= 1'b0;
    end else begin
      prev_q   <= filt;
      data_q   <= filt & ~gpio_oe & gpio_enable;
      status_q <= (status_q & ~int_clr_i) | set;
      int_q    <= |(status_q & int_en_i);
    end
  end

  assign gpio_data_o  = data_q;
  assign int_status_o = status_q;
  assign int_o        = int_q;

endmodule

// File: tb/tb_pb_gpio_ext.sv
// Bench for pb_gpio_ext: history-based model plus directed checks.
// Define PB_GPIO_EXT_DEBOUNCE_EN to exercise the debounce build.
module tb_pb_gpio_ext;

  localparam int W = 8;
  localparam int S = 2;
`ifdef PB_GPIO_EXT_DEBOUNCE_EN
  localparam int DC  = 4;
  localparam int LAT = 7;
`else
  localparam int DC  = 1;
  localparam int LAT = 3;
`endif

  logic clk = 1'b0;
  logic rst;
  logic [W-1:0] oe, en, dat, ien, irise, ifall, iclr, pad;
  wire  [W-1:0] dout, st;
  wire          irq;
  tri   [W-1:0] gpio;
  wire  [W-1:0] tb_drv = ~(oe & en);

  for (genvar i = 0; i < W; i++) begin : g_tb_pad
    assign gpio[i] = tb_drv[i] ? pad[i] : 1'bz;
  end

  pb_gpio_ext #(
    .WIDTH(W),
    .SYNC_STAGES(S),
    .DEBOUNCE_CYCLES(DC)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .gpio        (gpio),
    .gpio_oe     (oe),
    .gpio_enable (en),
    .gpio_data_i (dat),
    .gpio_data_o (dout),
    .int_en_i    (ien),
    .int_rise_i  (irise),
    .int_fall_i  (ifall),
    .int_clr_i   (iclr),
    .int_status_o(st),
    .int_o       (irq)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: pad samples per edge; filt is the sample S edges back
  // (or, with debounce, the last value held for DC straight syncs).
  logic [W-1:0] hist [$];
  logic [W-1:0] shist [$];
  logic [W-1:0] m_filt, m_prev, m_st, m_data;
  logic         m_int;
  bit           m_valid = 0;

  always @(posedge clk) begin : p_model
    logic [W-1:0] f, s, rs, fl, q, sets;
    if (rst) begin
      hist.delete();
      for (int k = 0; k < S; k++) hist.push_back('0);
      shist.delete();
      m_filt = '0; m_prev = '0; m_st = '0; m_data = '0; m_int = 1'b0;
      m_valid = 1;
    end else begin
      s = hist[hist.size()-S];
`ifdef PB_GPIO_EXT_DEBOUNCE_EN
      f = m_filt;
      shist.push_back(s);
      if (shist.size() > DC) void'(shist.pop_front());
      if (shist.size() == DC) begin
        for (int b = 0; b < W; b++) begin
          bit tog;
          tog = 1;
          for (int j = 0; j < DC; j++)
            if (shist[j][b] == f[b]) tog = 0;
          if (tog) m_filt[b] = ~f[b];
        end
      end
`else
      f = s;
`endif
      rs   = f & ~m_prev;
      fl   = ~f & m_prev;
      q    = ~oe & en & ien;
      sets = q & ((rs & irise) | (fl & ifall));
      m_int  = |(m_st & ien);
      m_st   = (m_st & ~iclr) | sets;
      m_data = f & ~oe & en;
      m_prev = f;
      hist.push_back(gpio);
      if (hist.size() > 8) void'(hist.pop_front());
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      check("model_data", dout, m_data);
      check("model_status", st, m_st);
      check("model_int", irq, m_int);
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clr_pulse(input logic [W-1:0] m);
    iclr = m;
    step(1);
    iclr = '0;
  endtask

  initial begin
    rst = 1'b1; oe = '0; en = '1; dat = '0; ien = '0;
    irise = '0; ifall = '0; iclr = '0; pad = '0;
    step(2);
    rst = 1'b0;
    check("rst_data", dout, 8'h00);
    check("rst_status", st, 8'h00);
    check("rst_int", irq, 1'b0);
    step(LAT + 1);

    // bit3 rising edge latency
    ien = 8'h08; irise = 8'h08; pad = 8'h08;
    step(LAT - 1);
    check("lat_data_early", dout, 8'h00);
    check("lat_status_early", st, 8'h00);
    step(1);
    check("lat_data", dout, 8'h08);
    check("lat_status", st, 8'h08);
    check("lat_int_early", irq, 1'b0);
    step(1);
    check("lat_int", irq, 1'b1);

    // clear racing a new edge
    pad = 8'h00;
    step(LAT + 1);
    pad = 8'h08;
    step(LAT - 1);
    iclr = 8'h08;
    step(1);
    iclr = '0;
    check("race_status", st, 8'h08);
    check("race_int", irq, 1'b1);
    step(1);
    clr_pulse(8'h08);
    check("clr_status", st, 8'h00);
    check("clr_int_hold", irq, 1'b1);
    step(1);
    check("clr_int", irq, 1'b0);

    // disabling int_en masks int_o but keeps status
    pad = 8'h00;
    step(LAT + 1);
    pad = 8'h08;
    step(LAT + 1);
    check("mask_pre_int", irq, 1'b1);
    ien = 8'h00;
    step(1);
    check("mask_status", st, 8'h08);
    check("mask_int", irq, 1'b0);
    clr_pulse(8'h08);

    // direction switch on bit5 with pad high
    ien = 8'h20; irise = 8'h20; ifall = 8'h20;
    dat = 8'h20; oe = 8'h20;
    step(LAT + 1);
    pad = 8'h28; oe = 8'h00;
    step(LAT + 2);
    check("dir_status", st, 8'h00);
    oe = 8'hFF; dat = 8'hA5;
    #1;
    check("drive_gpio", gpio, 8'hA5);
    step(1);
    oe = 8'h00; dat = 8'h00;
    step(LAT + 2);
    check("dir_status2", st, 8'h00);

    // both edges selected on bit0, then none
    clr_pulse(8'hFF);
    ien = 8'h01; irise = 8'h01; ifall = 8'h01;
    pad = 8'h29;
    step(LAT);
    check("both_rise", st, 8'h01);
    clr_pulse(8'h01);
    pad = 8'h28;
    step(LAT);
    check("both_fall", st, 8'h01);
    clr_pulse(8'h01);
    pad = 8'h29;
    step(LAT);
    check("both_rise2", st, 8'h01);
    irise = 8'h00; ifall = 8'h00;
    clr_pulse(8'h01);
    pad = 8'h28;
    step(LAT + 1);
    pad = 8'h29;
    step(LAT + 1);
    check("none_status", st, 8'h00);

    // simultaneous edges on several bits
    ien = 8'hFF; irise = 8'hFF; ifall = 8'h00;
    pad = 8'h00;
    step(LAT + 1);
    clr_pulse(8'hFF);
    pad = 8'h5A;
    step(LAT);
    check("multi_status", st, 8'h5A);
    step(1);
    check("multi_int", irq, 1'b1);

    // reset with full status and edges in flight
    pad = 8'hFF;
    step(LAT + 1);
    check("pre_rst_status", st, 8'hFF);
    pad = 8'h00;
    step(LAT + 1);
    pad = 8'hFF;
    step(LAT - 2);
    rst = 1'b1; pad = 8'h00;
    step(1);
    rst = 1'b0;
    check("rst2_data", dout, 8'h00);
    check("rst2_status", st, 8'h00);
    check("rst2_int", irq, 1'b0);
    step(LAT + 2);
    check("post_rst_quiet", st, 8'h00);
    pad = 8'hFF;
    step(LAT - 1);
    check("post_rst_early", st, 8'h00);
    step(1);
    check("post_rst_rise", st, 8'hFF);

`ifdef PB_GPIO_EXT_DEBOUNCE_EN
    // short glitch is filtered, long level is accepted
    ien = 8'h08; irise = 8'h08; ifall = 8'h08;
    pad = 8'h00;
    step(LAT + 1);
    clr_pulse(8'hFF);
    pad = 8'h08;
    step(3);
    pad = 8'h00;
    step(10);
    check("glitch_data", dout, 8'h00);
    check("glitch_status", st, 8'h00);
    pad = 8'h08;
    step(LAT - 1);
    check("db_data_early", dout, 8'h00);
    step(1);
    check("db_data", dout, 8'h08);
    check("db_status", st, 8'h08);
`endif

    step(2);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
